data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder on the MEM-stage side of the 5-stage pipeline.
//  - Accepts one load/store request at a time from the MEM stage.
//  - Holds the pipeline with stall_mem until the access completes.
//  - Returns sign/zero-extended load data on read_data_mem, sampled by the MEM->WB register.
// PARAMETERS
//  DEPTH_WORDS  1024  memory size in 32-bit words; word index = req_addr[31:2]
//  LATENCY      2     cycles from request acceptance to response; legal >= 1
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  req_valid      in   1   MEM stage presents a load/store; held stable while stall_mem=1
//  req_we         in   1   1=store, 0=load
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-aligned
//  req_funct3     in   3   RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  stall_mem      out  1   freeze IF..MEM while access is pending
//  resp_valid     out  1   one-cycle pulse: access complete this cycle
//  read_data_mem  out  32  formatted load data; held until the next response
//  misaligned     out  1   one-cycle pulse with resp_valid: access was suppressed
// BEHAVIOUR
//  - Reset (async): state=IDLE, counter=0. resp_valid, misaligned and read_data_mem are 0.
//    stall_mem is then req_valid, which is 0 under a compliant driver. Memory contents are not reset.
//  - FSM states IDLE, WAIT, DONE:
//    - IDLE->WAIT when req_valid and LATENCY>1; load counter with LATENCY-1.
//    - IDLE->DONE when req_valid and LATENCY==1.
//    - WAIT: decrement counter each cycle; go to DONE at counter==1.
//    - WAIT->IDLE if req_valid drops (abort, no write, no response).
//    - DONE->IDLE always (1 cycle). A new request is accepted the cycle after DONE.
//  - Latency: request first seen in IDLE at cycle 0 -> resp_valid=1 at cycle LATENCY.
//  - stall_mem = req_valid && state!=DONE (combinational). Low during DONE, so the pipeline advances.
//  - Loads:
//    - Read data is formatted from the addressed lanes and registered on entry to DONE.
//    - B/H sign-extend; BU/HU zero-extend; W passes through.
//  - Stores:
//    - Byte lanes come from addr[1:0] and size: SB 1 lane, SH 2 lanes, SW 4 lanes.
//    - The array write occurs on the edge leaving DONE. read_data_mem is unchanged.
//  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0):
//    - No array access.
//    - In DONE: misaligned=1; for loads read_data_mem=0.
//  - Out of range (addr[31:2] >= DEPTH_WORDS): load returns 0; store ignored; misaligned=0.
//  - Undefined funct3 (011, 110, 111): treated as W.
//  - Reset mid-operation: the access is aborted, a pending store is never written, and state returns to IDLE.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=2):
//     - each access: stall_mem high 2 cycles, resp_valid at cycle 2;
//     - LW returns 0xDEADBEEF.
//  2. After test 1, loads from 0x13:
//     - LB returns 0xFFFFFFDE;
//     - LBU returns 0x000000DE.
//     Loads from 0x12:
//     - LH returns 0xFFFFDEAD;
//     - LHU returns 0x0000DEAD.
//  3. SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 -> 0xDEAD55EF; other lanes unchanged.
//  4. Misaligned accesses:
//     - LW @0x12 -> misaligned=1, read_data_mem=0;
//     - SH @0x11 -> misaligned=1, memory unchanged on re-read.
//  5. Reset asserted during WAIT of SW @0x20 (old 0x0) -> outputs 0 immediately, LW @0x20 returns 0x0.
//  6. LATENCY=1 build: back-to-back LW/LW -> resp_valid at cycles 1 and 3, stall_mem high cycles 0 and 2 only.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time, fixed access latency,
// stalls the pipeline until done and returns sign/zero-extended load data.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall_mem,
    output logic        resp_valid,
    output logic [31:0] read_data_mem,
    output logic        misaligned
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // Access size: 0 = byte, 1 = half, 2 = word (undefined encodings behave as word)
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3)
            3'b000, 3'b100: sz = 2'd0;
            3'b001, 3'b101: sz = 2'd1;
            default:        sz = 2'd2;
        endcase
        return sz;
    endfunction

    function automatic logic is_mis(input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] sz;
        sz = size_of(f3);
        return ((sz == 2'd1) && off[0]) || ((sz == 2'd2) && (off != 2'b00));
    endfunction

    function automatic logic in_range(input logic [31:0] addr);
        return ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
    endfunction

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            enter_done;

    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic [31:0]     addr_reg;
    logic [31:0]     wdata_reg;

    logic            mis_reg;
    logic            resp_zero_reg;
    logic [2:0]      resp_f3_reg;
    logic [1:0]      resp_off_reg;

    // In IDLE the request is only visible on the ports; afterwards the captured copy is used
    logic            cur_we;
    logic [2:0]      cur_f3;
    logic [31:0]     cur_addr;
    logic            cur_mis;
    logic            cur_in_range;

    assign cur_we       = (state_reg == IDLE) ? req_we     : we_reg;
    assign cur_f3       = (state_reg == IDLE) ? req_funct3 : funct3_reg;
    assign cur_addr     = (state_reg == IDLE) ? req_addr   : addr_reg;
    assign cur_mis      = is_mis(cur_f3, cur_addr[1:0]);
    assign cur_in_range = in_range(cur_addr);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        enter_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_next = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_next = WAIT;
                        count_next = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (!req_valid) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count_reg == CW'(1)) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                    count_next = '0;
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            mis_reg       <= 1'b0;
            resp_zero_reg <= 1'b1;
            resp_f3_reg   <= 3'b000;
            resp_off_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if ((state_reg == IDLE) && req_valid) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
            end
            if (enter_done) begin
                mis_reg <= cur_mis;
                // Stores leave the returned load data untouched
                if (!cur_we) begin
                    resp_zero_reg <= cur_mis || !cur_in_range;
                    resp_f3_reg   <= cur_f3;
                    resp_off_reg  <= cur_addr[1:0];
                end
            end
        end
    end

    // Store lane steering, evaluated from the captured request while in DONE
    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;
    logic        write_en;
    logic        read_en;
    logic [AW-1:0] waddr_idx;
    logic [AW-1:0] raddr_idx;

    always_comb begin
        wr_be    = 4'b1111;
        wr_lanes = wdata_reg;
        case (size_of(funct3_reg))
            2'd0: begin
                wr_be    = 4'b0001 << addr_reg[1:0];
                wr_lanes = {4{wdata_reg[7:0]}};
            end
            2'd1: begin
                wr_be    = addr_reg[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_reg[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = wdata_reg;
            end
        endcase
    end

    assign write_en  = (state_reg == DONE) && we_reg && !mis_reg && in_range(addr_reg);
    assign read_en   = enter_done && !cur_we && !cur_mis && cur_in_range;
    assign waddr_idx = addr_reg[AW+1:2];
    assign raddr_idx = cur_addr[AW+1:2];

    logic [7:0]  lane_q [4];
    logic [31:0] rd_word;

    // One byte-wide array per lane so partial stores need no read-modify-write
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] q_reg;
            always_ff @(posedge clk) begin
                if (write_en && wr_be[gi]) begin
                    mem[waddr_idx] <= wr_lanes[8*gi +: 8];
                end
                if (read_en) begin
                    q_reg <= mem[raddr_idx];
                end
            end
            assign lane_q[gi] = q_reg;
        end
    endgenerate

    assign rd_word = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] fmt_data;

    always_comb begin
        byte_sel = rd_word[{resp_off_reg, 3'b000} +: 8];
        half_sel = resp_off_reg[1] ? rd_word[31:16] : rd_word[15:0];
        fmt_data = rd_word;
        case (size_of(resp_f3_reg))
            2'd0:    fmt_data = {{24{byte_sel[7] & ~resp_f3_reg[2]}}, byte_sel};
            2'd1:    fmt_data = {{16{half_sel[15] & ~resp_f3_reg[2]}}, half_sel};
            default: fmt_data = rd_word;
        endcase
    end

    assign read_data_mem = resp_zero_reg ? 32'h0 : fmt_data;
    assign stall_mem     = req_valid && (state_reg != DONE);
    assign resp_valid    = (state_reg == DONE);
    assign misaligned    = (state_reg == DONE) && mis_reg;

endmodule
